// File: rtl/gray_arb_pkg.sv
// Shared types and width helpers for gray_stream_arbiter and its tag FIFO.
package gray_arb_pkg;

  typedef enum logic {ARB, HOLD} arb_state_e;

  localparam int unsigned PerfWidth = 16;

  function automatic int unsigned tag_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/gray_tag_fifo.sv
// In-order FIFO of requester tags for pixels issued to the shared converter.
module gray_tag_fifo
  import gray_arb_pkg::*;
#(
  parameter int unsigned TagWidth = 2,
  parameter int unsigned Depth    = 4
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                push_i,
  input  logic [TagWidth-1:0] data_i,
  input  logic                pop_i,
  output logic [TagWidth-1:0] data_o,
  output logic                full_o,
  output logic                empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = count_width(Depth);

  logic [TagWidth-1:0] mem_q [Depth];
  logic [TagWidth-1:0] mem_d [Depth];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Count is kept apart from the pointers so full and empty stay distinct when they coincide.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/gray_stream_arbiter.sv
// Round-robin sharing of one rgb2gray converter among NumReq pixel streams, with tag-steered returns.
// Optional per-requester completion counters on perf_count_o when GRAY_ARB_PERF_EN is defined.
module gray_stream_arbiter
  import gray_arb_pkg::*;
#(
  parameter int unsigned DataWidth   = 8,
  parameter int unsigned NumReq      = 4,
  parameter int unsigned MaxInFlight = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic [NumReq-1:0]           req_valid_i,
  input  logic [NumReq*DataWidth-1:0] req_red_i,
  input  logic [NumReq*DataWidth-1:0] req_green_i,
  input  logic [NumReq*DataWidth-1:0] req_blue_i,
  output logic [NumReq-1:0]           req_ready_o,
  output logic [NumReq-1:0]           rsp_valid_o,
  output logic [DataWidth-1:0]        rsp_gray_o,
  input  logic [NumReq-1:0]           rsp_ready_i,
  output logic                        conv_valid_o,
  output logic [DataWidth-1:0]        conv_red_o,
  output logic [DataWidth-1:0]        conv_green_o,
  output logic [DataWidth-1:0]        conv_blue_o,
  input  logic                        conv_ready_i,
  input  logic                        conv_valid_i,
  input  logic [DataWidth-1:0]        conv_gray_i,
  output logic                        conv_ready_o
`ifdef GRAY_ARB_PERF_EN
  ,
  output logic [NumReq*PerfWidth-1:0] perf_count_o
`endif
);

  localparam int unsigned TagW = tag_width(NumReq);

  arb_state_e      state_q, state_d;
  logic [TagW-1:0] grant_q, grant_d;
  logic [TagW-1:0] rr_q, rr_d;
  logic [TagW-1:0] arb_grant, grant, head_tag;
  logic            fifo_full, fifo_empty;
  logic            can_issue, issue_hs, rsp_hs;

  always_comb begin : arb_search
    int unsigned idx;
    logic        found;
    arb_grant = rr_q;
    found     = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NumReq) idx = idx - NumReq;
      if (!found && req_valid_i[idx]) begin
        arb_grant = TagW'(idx);
        found     = 1'b1;
      end
    end
  end

  // Reset gates the issue side combinationally so nothing leaks out while reset_ni is low.
  assign grant     = (state_q == HOLD) ? grant_q : arb_grant;
  assign can_issue = reset_ni && !fifo_full;

  always_comb begin
    conv_valid_o       = req_valid_i[grant] && can_issue;
    conv_red_o         = req_red_i[grant*DataWidth +: DataWidth];
    conv_green_o       = req_green_i[grant*DataWidth +: DataWidth];
    conv_blue_o        = req_blue_i[grant*DataWidth +: DataWidth];
    req_ready_o        = '0;
    req_ready_o[grant] = conv_ready_i && can_issue;
  end

  assign issue_hs = conv_valid_o && conv_ready_i;

  always_comb begin
    state_d = (conv_valid_o && !conv_ready_i) ? HOLD : ARB;
    grant_d = grant;
    rr_d    = rr_q;
    if (issue_hs) begin
      rr_d = (grant == TagW'(NumReq - 1)) ? '0 : grant + TagW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ARB;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  gray_tag_fifo #(
    .TagWidth (TagW),
    .Depth    (MaxInFlight)
  ) u_tag_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .push_i   (issue_hs),
    .data_i   (grant),
    .pop_i    (rsp_hs),
    .data_o   (head_tag),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  // A converter result with no outstanding tag is never acknowledged.
  always_comb begin
    rsp_valid_o = '0;
    conv_ready_o = 1'b0;
    if (!fifo_empty) begin
      rsp_valid_o[head_tag] = conv_valid_i;
      conv_ready_o          = rsp_ready_i[head_tag];
    end
  end

  assign rsp_gray_o = conv_gray_i;
  assign rsp_hs     = conv_valid_i && conv_ready_o;

`ifdef GRAY_ARB_PERF_EN
  logic [PerfWidth-1:0] perf_q [NumReq];
  logic [PerfWidth-1:0] perf_d [NumReq];

  always_comb begin
    perf_d = perf_q;
    if (rsp_hs && (perf_q[head_tag] != '1)) begin
      perf_d[head_tag] = perf_q[head_tag] + PerfWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      perf_q <= '{default: '0};
    end else begin
      perf_q <= perf_d;
    end
  end

  always_comb begin
    perf_count_o = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      perf_count_o[k*PerfWidth +: PerfWidth] = perf_q[k];
    end
  end
`endif

endmodule
